// File: rtl/feedback_detector.sv
// Howl detector: envelope, zero-crossing period tracking and gain ramp.
// Optional macro FEEDBACK_DETECTOR_HYST_EN lowers the HOWL quiet level.
module feedback_detector #(
  parameter int unsigned LEVEL_THRESH    = 64,
  parameter int unsigned DECAY_SHIFT     = 4,
  parameter int unsigned PERIOD_W        = 10,
  parameter int unsigned PERIOD_TOL      = 1,
  parameter int unsigned HOLD_COUNT      = 4,
  parameter int unsigned RELEASE_SAMPLES = 32,
  parameter int unsigned GAIN_MIN        = 32
) (
  input  logic                i_clk,
  input  logic                i_reset_n,
  input  logic                i_valid,
  input  logic [7:0]          i_data,
  output logic                o_howl,
  output logic [PERIOD_W-1:0] o_period,
  output logic [7:0]          o_gain,
  output logic [1:0]          o_state
);

  localparam int unsigned SW = $clog2(HOLD_COUNT + 1);
  localparam int unsigned QW = $clog2(RELEASE_SAMPLES + 1);

  localparam logic [7:0] LOUD_LVL = 8'(LEVEL_THRESH);
`ifdef FEEDBACK_DETECTOR_HYST_EN
  localparam logic [7:0] QUIET_LVL = 8'(LEVEL_THRESH >> 1);
`else
  localparam logic [7:0] QUIET_LVL = 8'(LEVEL_THRESH);
`endif
  localparam logic [7:0]          GMIN  = 8'(GAIN_MIN);
  localparam logic [PERIOD_W-1:0] TOL   = PERIOD_W'(PERIOD_TOL);
  localparam logic [PERIOD_W-1:0] CMAX  = '1;
  localparam logic [SW-1:0]       HOLD  = SW'(HOLD_COUNT);
  localparam logic [QW-1:0]       QLAST = QW'(RELEASE_SAMPLES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    TRACK = 2'd1,
    HOWL  = 2'd2
  } state_e;

  state_e state_q, state_d;

  logic [7:0]          env_q, env_d;
  logic [PERIOD_W-1:0] cnt_q, cnt_d;
  logic [PERIOD_W-1:0] stored_q, stored_d;
  logic [PERIOD_W-1:0] period_q, period_d;
  logic [SW-1:0]       stable_q, stable_d;
  logic [QW-1:0]       quiet_q, quiet_d;
  logic                neg_q, neg_d;
  logic                armed_q, armed_d;
  logic [7:0]          gain_q, gain_d;

  logic [7:0]          abs_v;
  logic [7:0]          dec_v;
  logic                loud;
  logic                quiet;
  logic                xing;
  logic                meas_v;
  logic [PERIOD_W-1:0] meas;
  logic [PERIOD_W-1:0] dlt;
  logic                match;
  logic [SW-1:0]       stable_inc;

  assign abs_v      = i_data[7] ? (~i_data + 8'd1) : i_data;
  assign loud       = env_q >= LOUD_LVL;
  assign quiet      = env_q < QUIET_LVL;
  assign xing       = neg_q && !i_data[7];
  assign meas_v     = xing && armed_q;
  assign meas       = cnt_q + PERIOD_W'(1);
  assign dlt        = (meas >= stored_q) ? (meas - stored_q)
                                         : (stored_q - meas);
  assign match      = (cnt_q != CMAX) && (dlt <= TOL);
  assign stable_inc = stable_q + SW'(1);

  // Envelope follower, crossing detector and period counter
  always_comb begin
    env_d = env_q;
    cnt_d = cnt_q;
    neg_d = neg_q;
    dec_v = env_q >> DECAY_SHIFT;
    if (dec_v == 8'd0) dec_v = 8'd1;
    if (i_valid) begin
      neg_d = i_data[7];
      if (abs_v > env_q) begin
        env_d = abs_v;
      end else if (env_q != 8'd0) begin
        env_d = env_q - dec_v;
      end
      if (xing) begin
        cnt_d = '0;
      end else if (cnt_q != CMAX) begin
        cnt_d = cnt_q + PERIOD_W'(1);
      end
    end
  end

  // State register
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) state_q <= IDLE;
    else            state_q <= state_d;
  end

  // Next state plus period/stability/quiet bookkeeping
  always_comb begin
    state_d  = state_q;
    stored_d = stored_q;
    period_d = period_q;
    stable_d = stable_q;
    quiet_d  = quiet_q;
    armed_d  = armed_q;
    if (i_valid) begin
      if (xing) armed_d = 1'b1;
      unique case (state_q)
        IDLE: begin
          if (meas_v && loud) begin
            stored_d = meas;
            stable_d = '0;
            state_d  = TRACK;
          end
        end
        TRACK: begin
          if (!loud) begin
            state_d  = IDLE;
            stable_d = '0;
            armed_d  = 1'b0;
          end else if (meas_v) begin
            stored_d = meas;
            if (match) begin
              stable_d = stable_inc;
              if (stable_inc == HOLD) begin
                period_d = meas;
                state_d  = HOWL;
              end
            end else begin
              stable_d = '0;
            end
          end
        end
        HOWL: begin
          if (quiet && quiet_q == QLAST) begin
            state_d  = IDLE;
            quiet_d  = '0;
            stable_d = '0;
            armed_d  = 1'b0;
          end else begin
            quiet_d = quiet ? quiet_q + QW'(1) : '0;
            if (meas_v) begin
              stored_d = meas;
              if (match) period_d = meas;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Status outputs and the gain ramp
  always_comb begin
    o_howl  = (state_q == HOWL);
    o_state = state_q;
    gain_d  = gain_q;
    if (i_valid) begin
      if (state_q == HOWL) begin
        if (gain_q > GMIN) gain_d = gain_q - 8'd1;
      end else if (gain_q != 8'hFF) begin
        gain_d = gain_q + 8'd1;
      end
    end
  end

  // Datapath registers
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      env_q    <= '0;
      cnt_q    <= '0;
      stored_q <= '0;
      period_q <= '0;
      stable_q <= '0;
      quiet_q  <= '0;
      neg_q    <= 1'b0;
      armed_q  <= 1'b0;
      gain_q   <= 8'hFF;
    end else begin
      env_q    <= env_d;
      cnt_q    <= cnt_d;
      stored_q <= stored_d;
      period_q <= period_d;
      stable_q <= stable_d;
      quiet_q  <= quiet_d;
      neg_q    <= neg_d;
      armed_q  <= armed_d;
      gain_q   <= gain_d;
    end
  end

  assign o_period = period_q;
  assign o_gain   = gain_q;

endmodule
